bcd_alu_seq: RTL and testbench

- Digit-serial, parametrised BCD ALU. Supports N-digit packed-BCD add, subtract, nine's complement and magnitude compare.
- Processes one BCD digit per clock, LSB digit first, under a start/busy/done handshake.
- Produces a true BCD result with carry/borrow and error flags.
- Sits beside the combinational 4-digit BCD ALU as its wide-operand, low-area successor for datapaths that cannot afford an N-digit combinational adder.

---
 rtl/bcd_alu_seq.sv | 231 +++++++++++++++++++++++
 tb/tb_bcd_alu_seq.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_alu_seq.sv
// Digit-serial packed-BCD ALU: add, subtract, nine's complement and compare,
// one digit per clock, LSB first, under a start/busy/done handshake.
module bcd_alu_seq #(
    parameter int          DIGITS     = 4,
    parameter logic [3:0]  ERR_NIBBLE = 4'hC
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [1:0]          op,
    input  logic [4*DIGITS-1:0] a,
    input  logic [4*DIGITS-1:0] b,
    output logic                busy,
    output logic                done,
    output logic [4*DIGITS-1:0] c,
    output logic                carry,
    output logic                err
);

    localparam int W  = 4 * DIGITS;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_NC  = 2'b10;
    localparam logic [1:0] OP_CMP = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        CMP_EQ = 2'd0,
        CMP_GT = 2'd1,
        CMP_LT = 2'd2
    } cmp_t;

    // Handshake: start is sampled on a rising edge only while busy=0 (IDLE or
    // FIN); busy is high for exactly the DIGITS digit cycles; done pulses for
    // the single FIN cycle and c/carry/err are valid from that cycle onward.

    state_t          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [1:0]      op_q, op_d;
    logic            cy_q, cy_d;
    cmp_t            cmp_q, cmp_d;
    logic            err_sticky_q, err_sticky_d;
    logic [W-1:0]    res_q, res_d;
    logic [W-1:0]    c_q, c_d;
    logic            carry_q, carry_d;
    logic            err_q, err_d;

    // Per-digit datapath on the low nibble of the shifting operand registers.
    logic [3:0]      da, db, dig;
    logic [4:0]      sum, diff;
    logic            cy_nxt;
    cmp_t            cmp_nxt;
    logic            err_nxt;
    logic            launch;

    assign da   = a_q[3:0];
    assign db   = b_q[3:0];
    assign sum  = {1'b0, da} + {1'b0, db} + {4'b0, cy_q};
    assign diff = {1'b0, da} - {1'b0, db} - {4'b0, cy_q};

    always_comb begin
        dig     = 4'd0;
        cy_nxt  = cy_q;
        cmp_nxt = cmp_q;
        err_nxt = err_sticky_q;
        case (op_q)
            OP_ADD: begin
                if (sum > 5'd9) begin
                    dig    = 4'(sum - 5'd10);
                    cy_nxt = 1'b1;
                end else begin
                    dig    = sum[3:0];
                    cy_nxt = 1'b0;
                end
            end
            OP_SUB: begin
                // diff[4] is the sign of the 5-bit two's-complement difference.
                if (diff[4]) begin
                    dig    = 4'(diff + 5'd10);
                    cy_nxt = 1'b1;
                end else begin
                    dig    = diff[3:0];
                    cy_nxt = 1'b0;
                end
            end
            OP_NC: begin
                dig = 4'd9 - da;
            end
            default: begin
                if (da > db) begin
                    cmp_nxt = CMP_GT;
                end else if (da < db) begin
                    cmp_nxt = CMP_LT;
                end
            end
        endcase
        if ((da > 4'd9) || ((op_q != OP_NC) && (db > 4'd9))) begin
            err_nxt = 1'b1;
        end
    end

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        a_d          = a_q;
        b_d          = b_q;
        op_d         = op_q;
        cy_d         = cy_q;
        cmp_d        = cmp_q;
        err_sticky_d = err_sticky_q;
        res_d        = res_q;
        c_d          = c_q;
        carry_d      = carry_q;
        err_d        = err_q;
        launch       = 1'b0;

        case (state_q)
            S_IDLE: begin
                launch = start;
            end
            S_RUN: begin
                a_d          = a_q >> 4;
                b_d          = b_q >> 4;
                res_d        = res_q >> 4;
                res_d[W-1 -: 4] = dig;
                cy_d         = cy_nxt;
                cmp_d        = cmp_nxt;
                err_sticky_d = err_nxt;
                idx_d        = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    state_d = S_FIN;
                    idx_d   = '0;
                    if (err_nxt) begin
                        c_d     = {DIGITS{ERR_NIBBLE}};
                        carry_d = 1'b0;
                        err_d   = 1'b1;
                    end else begin
                        err_d = 1'b0;
                        case (op_q)
                            OP_CMP: begin
                                carry_d = 1'b0;
                                if (cmp_nxt == CMP_GT) begin
                                    c_d = W'(1);
                                end else if (cmp_nxt == CMP_LT) begin
                                    c_d = '1;
                                end else begin
                                    c_d = '0;
                                end
                            end
                            OP_NC: begin
                                c_d     = res_d;
                                carry_d = 1'b0;
                            end
                            default: begin
                                c_d     = res_d;
                                carry_d = cy_nxt;
                            end
                        endcase
                    end
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
                launch  = start;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A new request restarts the digit pipeline with cleared accumulators.
        if (launch) begin
            state_d      = S_RUN;
            idx_d        = '0;
            a_d          = a;
            b_d          = b;
            op_d         = op;
            cy_d         = 1'b0;
            cmp_d        = CMP_EQ;
            err_sticky_d = 1'b0;
            res_d        = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            a_q          <= '0;
            b_q          <= '0;
            op_q         <= OP_ADD;
            cy_q         <= 1'b0;
            cmp_q        <= CMP_EQ;
            err_sticky_q <= 1'b0;
            res_q        <= '0;
            c_q          <= '0;
            carry_q      <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            a_q          <= a_d;
            b_q          <= b_d;
            op_q         <= op_d;
            cy_q         <= cy_d;
            cmp_q        <= cmp_d;
            err_sticky_q <= err_sticky_d;
            res_q        <= res_d;
            c_q          <= c_d;
            carry_q      <= carry_d;
            err_q        <= err_d;
        end
    end

    assign busy  = (state_q == S_RUN);
    assign done  = (state_q == S_FIN);
    assign c     = c_q;
    assign carry = carry_q;
    assign err   = err_q;

endmodule

// File: tb/tb_bcd_alu_seq.sv
// Directed bench for bcd_alu_seq: table of 4-digit vectors, handshake corner
// sequences, and 1-digit / 8-digit instances for width boundaries.
module tb_bcd_alu_seq;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_NC  = 2'b10;
    localparam logic [1:0] OP_CMP = 2'b11;

    // clock / reset
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        start4 = 1'b0, start1 = 1'b0, start8 = 1'b0;
    logic [1:0]  op4 = '0, op1 = '0, op8 = '0;
    logic [15:0] a4 = '0, b4 = '0, c4;
    logic [3:0]  a1 = '0, b1 = '0, c1;
    logic [31:0] a8 = '0, b8 = '0, c8;
    logic        busy4, done4, carry4, err4;
    logic        busy1, done1, carry1, err1;
    logic        busy8, done8, carry8, err8;

    bcd_alu_seq #(.DIGITS(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .op(op4), .a(a4), .b(b4),
        .busy(busy4), .done(done4), .c(c4), .carry(carry4), .err(err4)
    );
    bcd_alu_seq #(.DIGITS(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .op(op1), .a(a1), .b(b1),
        .busy(busy1), .done(done1), .c(c1), .carry(carry1), .err(err1)
    );
    bcd_alu_seq #(.DIGITS(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .op(op8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .c(c8), .carry(carry8), .err(err8)
    );

    // instance selector for the shared driver / sampler
    int          sel = 4;
    logic        s_busy, s_done, s_carry, s_err;
    logic [31:0] s_c;

    always_comb begin
        case (sel)
            1: begin
                s_busy = busy1; s_done = done1; s_carry = carry1; s_err = err1;
                s_c = {28'b0, c1};
            end
            8: begin
                s_busy = busy8; s_done = done8; s_carry = carry8; s_err = err8;
                s_c = c8;
            end
            default: begin
                s_busy = busy4; s_done = done4; s_carry = carry4; s_err = err4;
                s_c = {16'b0, c4};
            end
        endcase
    end

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic st, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        case (sel)
            1:       begin start1 = st; op1 = o; a1 = x[3:0];  b1 = y[3:0];  end
            8:       begin start8 = st; op8 = o; a8 = x;       b8 = y;       end
            default: begin start4 = st; op4 = o; a4 = x[15:0]; b4 = y[15:0]; end
        endcase
    endtask

    // Issues one op from idle and waits (bounded) for done. lat counts the
    // cycle after the start edge as 1; lat=0 means done never came.
    task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] prev_c, output logic [31:0] rc,
                          output logic rcy, output logic rer, output int lat,
                          output int nbusy, output logic stable);
        @(negedge clk);
        drive(1'b1, o, x, y);
        @(posedge clk);
        @(negedge clk);
        drive(1'b0, 2'($urandom_range(3, 0)), $urandom, $urandom);
        lat = 0; nbusy = 0; stable = 1'b1;
        rc = 32'hDEAD_BEEF; rcy = 1'bx; rer = 1'bx;
        for (int k = 1; k <= 20; k++) begin
            if (s_busy) nbusy++;
            if (s_done) begin
                lat = k; rc = s_c; rcy = s_carry; rer = s_err;
                break;
            end
            if (s_c !== prev_c) stable = 1'b0;
            @(negedge clk);
        end
    endtask

    typedef struct {
        string       name;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        logic        cy;
        logic        er;
    } vec_t;

    vec_t tbl4[15];
    vec_t tbl1[4];
    vec_t tbl8[3];

    task automatic run_table(input vec_t v, input int digits, inout logic [31:0] prev);
        logic [31:0] rc;
        logic        rcy, rer, stable;
        int          lat, nbusy;
        run_op(v.op, v.a, v.b, prev, rc, rcy, rer, lat, nbusy, stable);
        chk({v.name, "_c"}, rc, v.c);
        chk({v.name, "_carry"}, {31'b0, rcy}, {31'b0, v.cy});
        chk({v.name, "_err"}, {31'b0, rer}, {31'b0, v.er});
        chk({v.name, "_latency"}, lat, digits + 1);
        chk({v.name, "_busy_cycles"}, nbusy, digits);
        chk({v.name, "_c_held"}, {31'b0, stable}, 32'd1);
        prev = v.c;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] prev;
        int          ndone, lat;
        logic [31:0] e;

        tbl4[0]  = '{"add_1234_5678", OP_ADD, 32'h1234, 32'h5678, 32'h6912, 1'b0, 1'b0};
        tbl4[1]  = '{"add_9999_0001", OP_ADD, 32'h9999, 32'h0001, 32'h0000, 1'b1, 1'b0};
        tbl4[2]  = '{"sub_0100_0200", OP_SUB, 32'h0100, 32'h0200, 32'h9900, 1'b1, 1'b0};
        tbl4[3]  = '{"sub_0500_0123", OP_SUB, 32'h0500, 32'h0123, 32'h0377, 1'b0, 1'b0};
        tbl4[4]  = '{"nc_0123",       OP_NC,  32'h0123, 32'hFFFF, 32'h9876, 1'b0, 1'b0};
        tbl4[5]  = '{"cmp_gt",        OP_CMP, 32'h5000, 32'h4999, 32'h0001, 1'b0, 1'b0};
        tbl4[6]  = '{"cmp_eq",        OP_CMP, 32'h4321, 32'h4321, 32'h0000, 1'b0, 1'b0};
        tbl4[7]  = '{"cmp_lt",        OP_CMP, 32'h0999, 32'h1000, 32'hFFFF, 1'b0, 1'b0};
        tbl4[8]  = '{"add_bad_a",     OP_ADD, 32'h12A4, 32'h0000, 32'hCCCC, 1'b0, 1'b1};
        tbl4[9]  = '{"add_clears_err",OP_ADD, 32'h0001, 32'h0002, 32'h0003, 1'b0, 1'b0};
        tbl4[10] = '{"sub_0000_0001", OP_SUB, 32'h0000, 32'h0001, 32'h9999, 1'b1, 1'b0};
        tbl4[11] = '{"add_5000_5000", OP_ADD, 32'h5000, 32'h5000, 32'h0000, 1'b1, 1'b0};
        tbl4[12] = '{"cmp_bad_b",     OP_CMP, 32'h1234, 32'h12A4, 32'hCCCC, 1'b0, 1'b1};
        tbl4[13] = '{"sub_4321_1234", OP_SUB, 32'h4321, 32'h1234, 32'h3087, 1'b0, 1'b0};
        tbl4[14] = '{"nc_bad_a",      OP_NC,  32'h00F0, 32'h0000, 32'hCCCC, 1'b0, 1'b1};

        tbl1[0] = '{"d1_add_9_9", OP_ADD, 32'h9, 32'h9, 32'h8, 1'b1, 1'b0};
        tbl1[1] = '{"d1_sub_3_5", OP_SUB, 32'h3, 32'h5, 32'h8, 1'b1, 1'b0};
        tbl1[2] = '{"d1_nc_2",    OP_NC,  32'h2, 32'hF, 32'h7, 1'b0, 1'b0};
        tbl1[3] = '{"d1_cmp_lt",  OP_CMP, 32'h3, 32'h7, 32'hF, 1'b0, 1'b0};

        tbl8[0] = '{"d8_add_wrap", OP_ADD, 32'h9999_9999, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0};
        tbl8[1] = '{"d8_sub_wrap", OP_SUB, 32'h0000_0000, 32'h0000_0001, 32'h9999_9999, 1'b1, 1'b0};
        tbl8[2] = '{"d8_cmp_lt",   OP_CMP, 32'h1234_5678, 32'h1234_5679, 32'hFFFF_FFFF, 1'b0, 1'b0};

        // reset state
        repeat (2) @(negedge clk);
        chk("reset_busy", {31'b0, busy4}, 32'd0);
        chk("reset_done", {31'b0, done4}, 32'd0);
        chk("reset_c", {16'b0, c4}, 32'd0);
        chk("reset_carry_err", {30'b0, carry4, err4}, 32'd0);
        rst_n = 1'b1;

        sel = 4;
        prev = 32'd0;
        for (int i = 0; i < 15; i++) run_table(tbl4[i], 4, prev);

        // start pulsed mid-RUN must be ignored
        @(negedge clk);
        drive(1'b1, OP_ADD, 32'h1111, 32'h2222);
        @(posedge clk);
        @(negedge clk);
        drive(1'b0, OP_ADD, 32'h0, 32'h0);
        @(negedge clk);
        drive(1'b1, OP_SUB, 32'h9999, 32'h0001);
        @(negedge clk);
        drive(1'b0, OP_SUB, 32'h0, 32'h0);
        lat = 0;
        for (int k = 3; k <= 20; k++) begin
            if (s_done) begin lat = k; break; end
            @(negedge clk);
        end
        chk("midrun_start_latency", lat, 5);
        chk("midrun_start_c", s_c, 32'h3333);
        chk("midrun_start_carry", {31'b0, s_carry}, 32'd0);
        @(negedge clk);
        chk("midrun_start_idle_after", {30'b0, s_busy, s_done}, 32'd0);

        // start held high: back-to-back ops, done every DIGITS+1 cycles
        @(negedge clk);
        drive(1'b1, OP_ADD, 32'h0001, 32'h0001);
        exp_q.push_back(32'h0002);
        @(posedge clk);
        @(negedge clk);
        ndone = 0;
        for (int k = 1; k <= 30; k++) begin
            if (s_done) begin
                ndone++;
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hBAD0_BAD0;
                chk("b2b_c", s_c, e);
                chk("b2b_spacing", k, 5 * ndone);
                if (ndone == 1) begin
                    drive(1'b1, OP_ADD, 32'h0005, 32'h0001);
                    exp_q.push_back(32'h0006);
                end else if (ndone == 2) begin
                    drive(1'b1, OP_ADD, 32'h0007, 32'h0001);
                    exp_q.push_back(32'h0008);
                end else begin
                    drive(1'b0, OP_ADD, 32'h0, 32'h0);
                    break;
                end
            end
            @(negedge clk);
        end
        chk("b2b_count", ndone, 3);
        @(negedge clk);
        chk("b2b_idle_after", {31'b0, s_busy}, 32'd0);

        // reset mid-RUN aborts with no done pulse
        @(negedge clk);
        drive(1'b1, OP_ADD, 32'h0002, 32'h0003);
        @(posedge clk);
        @(negedge clk);
        drive(1'b0, OP_ADD, 32'h0, 32'h0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_midrun_busy", {31'b0, busy4}, 32'd0);
        chk("rst_midrun_c", {16'b0, c4}, 32'd0);
        chk("rst_midrun_done", {31'b0, done4}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (done4 || busy4) ndone++;
        end
        chk("rst_midrun_no_done", ndone, 0);

        sel = 1;
        prev = 32'd0;
        for (int i = 0; i < 4; i++) run_table(tbl1[i], 1, prev);

        sel = 8;
        prev = 32'd0;
        for (int i = 0; i < 3; i++) run_table(tbl8[i], 8, prev);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
